// File: rtl/io_dma_arbiter_pkg.sv
// Shared definitions for the PS/2 / USB DMA arbiter: FSM encoding, mux source
// codes and the round-robin pick used at grant time.
package io_dma_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StXfer   = 2'd2,
    StAck    = 2'd3
  } arb_state_e;

  // Mux select codes; the I/O mux and its controllers decode the same values.
  localparam logic SRC_PS2 = 1'b1;
  localparam logic SRC_USB = 1'b0;

  // On a tie the source that was not served last wins.
  function automatic logic rr_pick(input logic req_ps2, input logic req_usb,
                                   input logic last_served);
    if (req_ps2 && req_usb) begin
      return ~last_served;
    end
    return req_ps2 ? SRC_PS2 : SRC_USB;
  endfunction

endpackage

// File: rtl/io_arb_cycle_counter.sv
// Up-counter with synchronous clear and a terminal-count flag; the count
// saturates at the terminal value so the flag stays asserted.
module io_arb_cycle_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] tc_value,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en && !tc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == tc_value);

endmodule

// File: rtl/io_dma_arbiter.sv
// Round-robin arbiter between the PS/2 and USB controllers for the shared DMA
// mux: grant, settle, DMA start/done handshake with timeout, acknowledge.
module io_dma_arbiter
  import io_dma_arbiter_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_ps2,
  input  logic             req_usb,
  input  logic             dma_ready,
  input  logic             dma_done,
  output logic             sel,
  output logic             dma_start,
  output logic             ack_ps2,
  output logic             ack_usb,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] cnt_ps2,
  output logic [CNT_W-1:0] cnt_usb
);

  localparam int unsigned SettleW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES);
  localparam logic [SettleW-1:0]  SettleTc  = SettleW'(SETTLE_CYCLES - 1);
  localparam logic [TimeoutW-1:0] TimeoutTc = TimeoutW'(TIMEOUT_CYCLES - 1);

  arb_state_e state_q, state_d;
  logic sel_q, sel_d;
  logic last_q, last_d;
  logic busy_q, busy_d;
  logic start_q, start_d;
  logic ack_ps2_q, ack_ps2_d;
  logic ack_usb_q, ack_usb_d;
  logic tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_ps2_q, cnt_ps2_d;
  logic [CNT_W-1:0] cnt_usb_q, cnt_usb_d;

  logic settle_clr, settle_en, settle_tc;
  logic tmo_clr, tmo_en, tmo_tc;
  logic [SettleW-1:0]  settle_count;
  logic [TimeoutW-1:0] tmo_count;
  logic granted_req;

  io_arb_cycle_counter #(
    .WIDTH(SettleW)
  ) u_settle_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (settle_clr),
    .en      (settle_en),
    .tc_value(SettleTc),
    .count   (settle_count),
    .tc      (settle_tc)
  );

  io_arb_cycle_counter #(
    .WIDTH(TimeoutW)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmo_clr),
    .en      (tmo_en),
    .tc_value(TimeoutTc),
    .count   (tmo_count),
    .tc      (tmo_tc)
  );

  assign granted_req = (sel_q == SRC_PS2) ? req_ps2 : req_usb;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    busy_d     = busy_q;
    start_d    = 1'b0;
    ack_ps2_d  = 1'b0;
    ack_usb_d  = 1'b0;
    tmo_d      = 1'b0;
    cnt_ps2_d  = cnt_ps2_q;
    cnt_usb_d  = cnt_usb_q;
    settle_clr = 1'b0;
    settle_en  = 1'b0;
    tmo_clr    = 1'b0;
    tmo_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (req_ps2 || req_usb) begin
          sel_d      = rr_pick(req_ps2, req_usb, last_q);
          busy_d     = 1'b1;
          settle_clr = 1'b1;
          state_d    = StSettle;
        end
      end
      StSettle: begin
        settle_en = 1'b1;
        // A withdrawn request cancels the grant without touching fairness state.
        if (!granted_req) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (settle_tc && dma_ready) begin
          start_d = 1'b1;
          tmo_clr = 1'b1;
          state_d = StXfer;
        end
      end
      StXfer: begin
        tmo_en = 1'b1;
        // dma_done coinciding with the start pulse belongs to no transfer.
        if (dma_done && !start_q) begin
          last_d  = sel_q;
          state_d = StAck;
          if (sel_q == SRC_PS2) begin
            ack_ps2_d = 1'b1;
            cnt_ps2_d = cnt_ps2_q + 1'b1;
          end else begin
            ack_usb_d = 1'b1;
            cnt_usb_d = cnt_usb_q + 1'b1;
          end
        end else if (tmo_tc) begin
          tmo_d   = 1'b1;
          busy_d  = 1'b0;
          last_d  = sel_q;
          state_d = StIdle;
        end
      end
      StAck: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sel_q     <= SRC_USB;
      last_q    <= SRC_USB;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      ack_ps2_q <= 1'b0;
      ack_usb_q <= 1'b0;
      tmo_q     <= 1'b0;
      cnt_ps2_q <= '0;
      cnt_usb_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      start_q   <= start_d;
      ack_ps2_q <= ack_ps2_d;
      ack_usb_q <= ack_usb_d;
      tmo_q     <= tmo_d;
      cnt_ps2_q <= cnt_ps2_d;
      cnt_usb_q <= cnt_usb_d;
    end
  end

  assign sel         = sel_q;
  assign dma_start   = start_q;
  assign ack_ps2     = ack_ps2_q;
  assign ack_usb     = ack_usb_q;
  assign busy        = busy_q;
  assign timeout_err = tmo_q;
  assign cnt_ps2     = cnt_ps2_q;
  assign cnt_usb     = cnt_usb_q;

endmodule

// File: tb/tb_io_dma_arbiter.sv
// Directed bench for io_dma_arbiter: single grant, round robin, ready stall,
// timeout, request withdrawal, async reset, counter wrap and stray dma_done.
module tb_io_dma_arbiter;

  localparam int unsigned Settle = 1;
  localparam int unsigned Tmo    = 16;
  localparam int unsigned Cw     = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_ps2 = 1'b0, req_usb = 1'b0, dma_ready = 1'b0, dma_done = 1'b0;
  logic sel, dma_start, ack_ps2, ack_usb, busy, timeout_err;
  logic [Cw-1:0] cnt_ps2, cnt_usb;

  int vectors = 0;
  int miscompares = 0;

  io_dma_arbiter #(
    .SETTLE_CYCLES (Settle),
    .TIMEOUT_CYCLES(Tmo),
    .CNT_W         (Cw)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_ps2    (req_ps2),
    .req_usb    (req_usb),
    .dma_ready  (dma_ready),
    .dma_done   (dma_done),
    .sel        (sel),
    .dma_start  (dma_start),
    .ack_ps2    (ack_ps2),
    .ack_usb    (ack_usb),
    .busy       (busy),
    .timeout_err(timeout_err),
    .cnt_ps2    (cnt_ps2),
    .cnt_usb    (cnt_usb)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req_ps2 = 1'b0; req_usb = 1'b0; dma_ready = 1'b0; dma_done = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Leaves the bench in the dma_start cycle; ok=0 if it never came.
  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (dma_start === 1'b1) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  // From the start cycle S, pulse dma_done in cycle S+d; returns in the ack cycle.
  task automatic finish_xfer(input int d);
    for (int i = 0; i < d; i++) tick();
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    vectors++;
    if ({sel, dma_start, ack_ps2, ack_usb, busy, timeout_err, cnt_ps2, cnt_usb} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got sel=%b start=%b ack=%b%b busy=%b tmo=%b cnt=%0d/%0d, want all 0",
               sel, dma_start, ack_ps2, ack_usb, busy, timeout_err, cnt_ps2, cnt_usb);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ps2_single();
    req_ps2 = 1'b1; dma_ready = 1'b1;
    tick();
    vectors++;
    if ({busy, sel, dma_start} !== 3'b110) begin
      miscompares++;
      $display("FAIL single_grant: got busy/sel/start=%b%b%b want 110", busy, sel, dma_start);
    end
    tick();
    vectors++;
    if (dma_start !== 1'b1) begin
      miscompares++;
      $display("FAIL single_start_c2: got dma_start=%b want 1", dma_start);
    end
    finish_xfer(5);
    vectors++;
    if ({ack_ps2, ack_usb, cnt_ps2, busy} !== {2'b10, 4'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL single_ack: got ack=%b%b cnt_ps2=%0d busy=%b want ack=10 cnt=1 busy=1",
               ack_ps2, ack_usb, cnt_ps2, busy);
    end
    req_ps2 = 1'b0;
    tick();
    vectors++;
    if ({ack_ps2, busy, sel} !== 3'b001) begin
      miscompares++;
      $display("FAIL single_idle: got ack_ps2=%b busy=%b sel=%b want 0 0 1", ack_ps2, busy, sel);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic exp_sel;
    apply_reset();
    req_ps2 = 1'b1; req_usb = 1'b1; dma_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_sel = (k % 2 == 0) ? 1'b1 : 1'b0;
      wait_start(ok);
      vectors++;
      if (!ok || sel !== exp_sel) begin
        miscompares++;
        $display("FAIL rr_grant%0d: got started=%b sel=%b want 1 sel=%b", k, ok, sel, exp_sel);
      end
      finish_xfer(3);
      vectors++;
      if ({ack_ps2, ack_usb} !== {exp_sel, ~exp_sel}) begin
        miscompares++;
        $display("FAIL rr_ack%0d: got ack_ps2/usb=%b%b want %b%b", k, ack_ps2, ack_usb,
                 exp_sel, ~exp_sel);
      end
      tick();
    end
    vectors++;
    if (cnt_ps2 !== 4'd2 || cnt_usb !== 4'd2) begin
      miscompares++;
      $display("FAIL rr_counts: got ps2=%0d usb=%0d want 2 2", cnt_ps2, cnt_usb);
    end
    req_ps2 = 1'b0; req_usb = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_ready_stall();
    req_ps2 = 1'b1; dma_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      vectors++;
      if ({dma_start, busy, sel} !== 3'b011) begin
        miscompares++;
        $display("FAIL stall_c%0d: got start/busy/sel=%b%b%b want 011", i, dma_start, busy, sel);
      end
    end
    dma_ready = 1'b1;
    tick();
    vectors++;
    if (dma_start !== 1'b1 || sel !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release: got start=%b sel=%b want 1 1", dma_start, sel);
    end
    finish_xfer(2);
    vectors++;
    if (ack_ps2 !== 1'b1 || cnt_ps2 !== 4'd3) begin
      miscompares++;
      $display("FAIL stall_ack: got ack_ps2=%b cnt_ps2=%0d want 1 3", ack_ps2, cnt_ps2);
    end
    req_ps2 = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    bit ok;
    req_ps2 = 1'b1; req_usb = 1'b1; dma_ready = 1'b1;
    wait_start(ok);
    vectors++;
    if (!ok || sel !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_grant: got started=%b sel=%b want 1 sel=0", ok, sel);
    end
    for (int i = 1; i <= 15; i++) begin
      tick();
      vectors++;
      if ({timeout_err, ack_ps2, ack_usb, busy} !== 4'b0001) begin
        miscompares++;
        $display("FAIL tmo_wait_c%0d: got tmo/ack/busy=%b%b%b%b want 0001", i,
                 timeout_err, ack_ps2, ack_usb, busy);
      end
    end
    tick();
    vectors++;
    if ({timeout_err, ack_ps2, ack_usb, busy} !== 4'b1000 || cnt_usb !== 4'd2) begin
      miscompares++;
      $display("FAIL tmo_pulse: got tmo/ack/busy=%b%b%b%b cnt_usb=%0d want 1000 cnt=2",
               timeout_err, ack_ps2, ack_usb, busy, cnt_usb);
    end
    tick();
    vectors++;
    if ({timeout_err, busy, sel} !== 3'b011) begin
      miscompares++;
      $display("FAIL tmo_next_tie: got tmo/busy/sel=%b%b%b want 011", timeout_err, busy, sel);
    end
    wait_start(ok);
    finish_xfer(2);
    vectors++;
    if (!ok || ack_ps2 !== 1'b1) begin
      miscompares++;
      $display("FAIL tmo_recover: got started=%b ack_ps2=%b want 1 1", ok, ack_ps2);
    end
    req_ps2 = 1'b0; req_usb = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_drop_and_reset();
    bit ok;
    req_usb = 1'b1; dma_ready = 1'b0;
    tick();
    vectors++;
    if ({busy, sel} !== 2'b10) begin
      miscompares++;
      $display("FAIL drop_grant: got busy/sel=%b%b want 10", busy, sel);
    end
    req_usb = 1'b0;
    tick();
    dma_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({busy, dma_start, ack_ps2, ack_usb} !== 4'b0000) begin
        miscompares++;
        $display("FAIL drop_abort%0d: got busy/start/ack=%b%b%b%b want 0000", i,
                 busy, dma_start, ack_ps2, ack_usb);
      end
      tick();
    end
    // Last served is still PS2, so a tie now goes to USB.
    req_ps2 = 1'b1; req_usb = 1'b1;
    tick();
    vectors++;
    if ({busy, sel} !== 2'b10) begin
      miscompares++;
      $display("FAIL drop_fairness: got busy/sel=%b%b want 10", busy, sel);
    end
    wait_start(ok);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (!ok || {sel, dma_start, ack_ps2, ack_usb, busy, timeout_err, cnt_ps2, cnt_usb} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got started=%b sel=%b start=%b busy=%b cnt=%0d/%0d want all 0",
               ok, sel, dma_start, busy, cnt_ps2, cnt_usb);
    end
    req_ps2 = 1'b0; req_usb = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_wrap_and_stray_done();
    bit ok;
    bit all_ok = 1'b1;
    req_usb = 1'b1; dma_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      wait_start(ok);
      all_ok &= ok;
      finish_xfer(1);
      tick();
    end
    vectors++;
    if (!all_ok || cnt_usb !== 4'd15) begin
      miscompares++;
      $display("FAIL wrap_pre: got started=%b cnt_usb=%0d want 1 15", all_ok, cnt_usb);
    end
    wait_start(ok);
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    vectors++;
    if (!ok || ack_usb !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL done_on_start: got started=%b ack_usb=%b busy=%b want 1 0 1", ok,
               ack_usb, busy);
    end
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    vectors++;
    if (ack_usb !== 1'b1 || cnt_usb !== 4'd0) begin
      miscompares++;
      $display("FAIL wrap: got ack_usb=%b cnt_usb=%0d want 1 0", ack_usb, cnt_usb);
    end
    req_usb = 1'b0;
    tick();
    tick();
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    tick();
    vectors++;
    if ({ack_ps2, ack_usb, busy, cnt_ps2, cnt_usb} !== '0) begin
      miscompares++;
      $display("FAIL done_in_idle: got ack=%b%b busy=%b cnt=%0d/%0d want all 0",
               ack_ps2, ack_usb, busy, cnt_ps2, cnt_usb);
    end
  endtask

  initial begin
    test_reset();
    test_ps2_single();
    test_round_robin();
    test_ready_stall();
    test_timeout();
    test_drop_and_reset();
    test_wrap_and_stray_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
